// File: rtl/seq_det_rr_scheduler_pkg.sv
// Shared "101" detector state encoding and next-state function.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GOT1  = 2'd1,
    S_GOT10 = 2'd2,
    S_MATCH = 2'd3
  } det_state_t;

  // Overlapping "101" detector; S_MATCH behaves like "seen ...101".
  function automatic det_state_t next_state(input det_state_t state, input logic in_bit);
    det_state_t ns;
    ns = S_IDLE;
    case (state)
      S_IDLE:  ns = in_bit ? S_GOT1  : S_IDLE;
      S_GOT1:  ns = in_bit ? S_GOT1  : S_GOT10;
      S_GOT10: ns = in_bit ? S_MATCH : S_IDLE;
      S_MATCH: ns = in_bit ? S_GOT1  : S_GOT10;
      default: ns = S_IDLE;
    endcase
    return ns;
  endfunction

endpackage

// File: rtl/seq_det_rr_scheduler_if.sv
// Requester lanes plus match event output of the shared detector.
interface seq_det_rr_scheduler_if #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
);
  logic [N_CH-1:0] req_valid;
  logic [N_CH-1:0] req_bit;
  logic [N_CH-1:0] req_ready;
  logic [N_CH-1:0] chan_clr;
  logic            match_valid;
  logic [CH_W-1:0] match_ch;

  // Requesters / event logger side
  modport master (
    output req_valid, req_bit, chan_clr,
    input  req_ready, match_valid, match_ch
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_bit, chan_clr,
    output req_ready, match_valid, match_ch
  );
endinterface

// File: rtl/seq_det_rr_scheduler_rr_arbiter.sv
// Wrap-around round-robin priority search starting at ptr.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int CW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [CW-1:0] gnt_idx,
  output logic          gnt_any
);

  // First requester at or above ptr wins, wrapping N-1 -> 0
  always_comb begin
    int idx;
    logic [CW-1:0] idx_c;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    idx_c   = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      idx_c = CW'(idx);
      if (!gnt_any && req[idx_c]) begin
        gnt_any      = 1'b1;
        gnt_idx      = idx_c;
        gnt[idx_c]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_det_rr_scheduler.sv
// One "101" detector engine time-shared across N_CH serial channels.
module seq_det_rr_scheduler
  import seq_det_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  seq_det_rr_scheduler_if.slave bus
);

  det_state_t      ctx_q [N_CH];
  det_state_t      ctx_d [N_CH];
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            match_valid_q, match_valid_d;
  logic [CH_W-1:0] match_ch_q, match_ch_d;

  logic [N_CH-1:0] eligible;
  logic [N_CH-1:0] gnt;
  logic [CH_W-1:0] gnt_idx;
  logic            gnt_any;
  det_state_t      gnt_next;

  // Channels being cleared are never offered; nothing is granted during reset
  assign eligible = reset ? '0 : (bus.req_valid & ~bus.chan_clr);

  rr_arbiter #(.N(N_CH), .CW(CH_W)) u_arb (
    .req     (eligible),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign bus.req_ready   = gnt;
  assign bus.match_valid = match_valid_q;
  assign bus.match_ch    = match_ch_q;

  // Shared engine: next state of the granted channel's context
  always_comb begin
    gnt_next = next_state(ctx_q[gnt_idx], bus.req_bit[gnt_idx]);
  end

  // Context update: a clear wins, otherwise only the granted context advances
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      ctx_d[i] = ctx_q[i];
      if (bus.chan_clr[i]) begin
        ctx_d[i] = S_IDLE;
      end else if (gnt[i]) begin
        ctx_d[i] = gnt_next;
      end
    end
  end

  // Pointer advance past the winner and the registered match event
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    match_valid_d = 1'b0;
    match_ch_d    = match_ch_q;
    if (gnt_any) begin
      rr_ptr_d = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
      if (gnt_next == S_MATCH) begin
        match_valid_d = 1'b1;
        match_ch_d    = gnt_idx;
      end
    end
  end

  // State registers; reset drops partial patterns and any pending match
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) ctx_q[i] <= S_IDLE;
      rr_ptr_q      <= '0;
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) ctx_q[i] <= ctx_d[i];
      rr_ptr_q      <= rr_ptr_d;
      match_valid_q <= match_valid_d;
      match_ch_q    <= match_ch_d;
    end
  end

endmodule

// File: tb/tb_seq_det_rr_scheduler.sv
// Bench for seq_det_rr_scheduler: directed scenarios plus random traffic
// checked against a "last three accepted bits == 101" reference model.
module tb_seq_det_rr_scheduler;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] drv_valid = '0, drv_bit = '0, drv_clr = '0;

  seq_det_rr_scheduler_if #(.N_CH(N)) bus ();
  assign bus.req_valid = drv_valid;
  assign bus.req_bit   = drv_bit;
  assign bus.chan_clr  = drv_clr;

  seq_det_rr_scheduler #(.N_CH(N)) dut (.clk(clk), .reset(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per-channel last three accepted bits, pointer, pending event
  logic [2:0] m_hist [N];
  int         m_ptr = 0;
  logic       m_mv = 1'b0;
  logic [1:0] m_mch = '0;

  // Observed / expected values for the current cycle
  logic [N-1:0] obs_ready, exp_ready;
  logic         obs_mv, exp_mv;
  logic [1:0]   obs_mch, exp_mch;

  // Directed bit streams, bit 0 sent first
  logic [7:0] s_bits [N];
  int         s_len  [N];
  int         s_pos  [N];

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic clear_streams();
    for (int i = 0; i < N; i++) begin s_bits[i] = '0; s_len[i] = 0; s_pos[i] = 0; end
  endtask

  task automatic load_stream(input int ch, input int len, input logic [7:0] bits);
    s_bits[ch] = bits; s_len[ch] = len; s_pos[ch] = 0;
  endtask

  task automatic apply_streams();
    for (int i = 0; i < N; i++) begin
      drv_valid[i] = (s_pos[i] < s_len[i]);
      drv_bit[i]   = drv_valid[i] ? s_bits[i][s_pos[i]] : 1'b0;
    end
  endtask

  // One clock: sample at negedge, compute expectations, advance model at posedge
  task automatic tick();
    logic [N-1:0] elig;
    int g;
    @(negedge clk);
    obs_ready = bus.req_ready;
    obs_mv    = bus.match_valid;
    obs_mch   = bus.match_ch;
    exp_mv    = m_mv;
    exp_mch   = m_mch;
    elig      = drv_valid & ~drv_clr;
    g = -1;
    if (!rst)
      for (int k = 0; k < N; k++)
        if (g < 0 && elig[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_ready = (g >= 0) ? (N'(1) << g) : '0;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) m_hist[i] = '0;
      m_ptr = 0; m_mv = 1'b0; m_mch = '0;
    end else begin
      m_mv = 1'b0;
      if (g >= 0) begin
        m_hist[g] = {m_hist[g][1:0], drv_bit[g]};
        if (m_hist[g] == 3'b101) begin m_mv = 1'b1; m_mch = 2'(g); end
        m_ptr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++) if (drv_clr[i]) m_hist[i] = '0;
    end
    for (int i = 0; i < N; i++) if (obs_ready[i] && s_pos[i] < s_len[i]) s_pos[i]++;
    #1;
  endtask

  task automatic stream_tick();
    apply_streams();
    tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; drv_valid = '0; drv_clr = '0; drv_bit = '0;
    clear_streams();
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drv_valid = 4'($urandom); drv_bit = 4'($urandom);
      tick();
      checks++;
      if (obs_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready cyc=%0d got=%b exp=0000", c, obs_ready); end
      if (c > 0) begin
        checks++;
        if (obs_mv !== 1'b0 || obs_mch !== 2'd0) begin errors++; $display("FAIL reset_match cyc=%0d got mv=%b ch=%0d exp mv=0 ch=0", c, obs_mv, obs_mch); end
      end
    end
    rst = 1'b0; drv_valid = '0;
    tick();
    checks++;
    if (obs_ready !== 4'b0000 || obs_mv !== 1'b0) begin errors++; $display("FAIL reset_idle got ready=%b mv=%b exp ready=0000 mv=0", obs_ready, obs_mv); end
    $display("test_reset done");
  endtask

  task automatic test_single_stream();
    logic [5:0] pulses = '0;
    do_reset(2);
    load_stream(0, 5, 8'b0001_0101);
    for (int c = 0; c < 6; c++) begin
      stream_tick();
      if (obs_mv) pulses[c] = 1'b1;
      checks++;
      if (obs_ready !== exp_ready || (c < 5 && obs_ready !== 4'b0001)) begin errors++; $display("FAIL single_ready cyc=%0d got=%b exp=%b", c, obs_ready, exp_ready); end
      checks++;
      if (obs_mv !== exp_mv || (exp_mv && obs_mch !== exp_mch)) begin errors++; $display("FAIL single_match cyc=%0d got mv=%b ch=%0d exp mv=%b ch=%0d", c, obs_mv, obs_mch, exp_mv, exp_mch); end
    end
    tick();
    if (obs_mv) pulses[5] = 1'b1;
    checks++;
    if (pulses !== 6'b10_1000) begin errors++; $display("FAIL single_pulses got=%b exp=101000", pulses); end
    $display("test_single_stream pulses=%b", pulses);
  endtask

  task automatic test_interleave();
    int exp_g [6] = '{0, 1, 0, 1, 0, 1};
    int npulse = 0;
    do_reset(2);
    load_stream(0, 3, 8'b0000_0101);
    load_stream(1, 3, 8'b0000_0000);
    for (int c = 0; c < 8; c++) begin
      stream_tick();
      if (c < 6) begin
        checks++;
        if (idx_of(obs_ready) != exp_g[c]) begin errors++; $display("FAIL interleave_grant cyc=%0d got=%0d exp=%0d", c, idx_of(obs_ready), exp_g[c]); end
      end
      if (obs_mv) begin
        npulse++;
        checks++;
        if (c != 5 || obs_mch !== 2'd0) begin errors++; $display("FAIL interleave_pulse cyc=%0d got ch=%0d exp cyc=5 ch=0", c, obs_mch); end
      end
      checks++;
      if (obs_mv !== exp_mv || obs_ready !== exp_ready) begin errors++; $display("FAIL interleave_model cyc=%0d got ready=%b mv=%b exp ready=%b mv=%b", c, obs_ready, obs_mv, exp_ready, exp_mv); end
    end
    checks++;
    if (npulse != 1) begin errors++; $display("FAIL interleave_count got=%0d exp=1", npulse); end
    $display("test_interleave pulses=%0d", npulse);
  endtask

  task automatic test_back_to_back();
    do_reset(2);
    load_stream(0, 3, 8'b0000_0101);
    load_stream(1, 3, 8'b0000_0101);
    for (int c = 0; c < 8; c++) begin
      stream_tick();
      checks++;
      if (obs_mv !== ((c == 5) || (c == 6)) || (obs_mv && obs_mch !== 2'(c - 5))) begin
        errors++; $display("FAIL b2b_match cyc=%0d got mv=%b ch=%0d", c, obs_mv, obs_mch);
      end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_contention();
    do_reset(2);
    for (int i = 0; i < N; i++) load_stream(i, 8, 8'($urandom));
    for (int c = 0; c < 8; c++) begin
      stream_tick();
      checks++;
      if (obs_ready !== (4'b0001 << (c % 4)) || !$onehot0(obs_ready)) begin errors++; $display("FAIL contention_grant cyc=%0d got=%b exp=%b", c, obs_ready, 4'b0001 << (c % 4)); end
      checks++;
      if (obs_mv !== exp_mv || (exp_mv && obs_mch !== exp_mch)) begin errors++; $display("FAIL contention_match cyc=%0d got mv=%b ch=%0d exp mv=%b ch=%0d", c, obs_mv, obs_mch, exp_mv, exp_mch); end
    end
    $display("test_contention done");
  endtask

  task automatic test_clear_mid();
    int npulse = 0;
    do_reset(2);
    load_stream(2, 2, 8'b0000_0001);
    stream_tick(); stream_tick();
    drv_valid = '0; drv_clr = 4'b0100;
    tick();
    drv_clr = '0;
    load_stream(2, 1, 8'b0000_0001);
    stream_tick(); stream_tick();
    checks++;
    if (obs_mv !== 1'b0) begin errors++; $display("FAIL clear_mid_nomatch got=%b exp=0", obs_mv); end
    load_stream(2, 2, 8'b0000_0010);
    for (int c = 0; c < 3; c++) begin
      stream_tick();
      if (obs_mv) npulse++;
      checks++;
      if (obs_mv !== exp_mv || (exp_mv && obs_mch !== 2'd2)) begin errors++; $display("FAIL clear_mid_match cyc=%0d got mv=%b ch=%0d exp mv=%b ch=2", c, obs_mv, obs_mch, exp_mv); end
    end
    checks++;
    if (npulse != 1) begin errors++; $display("FAIL clear_mid_count got=%0d exp=1", npulse); end
    $display("test_clear_mid pulses=%0d", npulse);
  endtask

  task automatic test_clear_collide();
    do_reset(2);
    load_stream(1, 2, 8'b0000_0001);
    stream_tick(); stream_tick();
    load_stream(0, 1, 8'b0000_0001);
    stream_tick();
    clear_streams();
    drv_valid = 4'b0011; drv_bit = 4'b0010; drv_clr = 4'b0010;
    tick();
    checks++;
    if (obs_ready !== 4'b0001 || exp_ready !== 4'b0001) begin errors++; $display("FAIL collide_ready got=%b exp=0001", obs_ready); end
    drv_clr = '0;
    tick();
    checks++;
    if (obs_ready !== 4'b0010) begin errors++; $display("FAIL collide_ptr got=%b exp=0010", obs_ready); end
    drv_valid = '0;
    tick();
    checks++;
    if (obs_mv !== 1'b0 || exp_mv !== 1'b0) begin errors++; $display("FAIL collide_ctx got mv=%b exp mv=0", obs_mv); end
    $display("test_clear_collide done");
  endtask

  task automatic test_reset_mid();
    do_reset(2);
    load_stream(3, 2, 8'b0000_0001);
    stream_tick(); stream_tick();
    clear_streams();
    rst = 1'b1; drv_valid = 4'b1000; drv_bit = 4'b1000;
    tick();
    checks++;
    if (obs_ready !== 4'b0000) begin errors++; $display("FAIL resetmid_ready got=%b exp=0000", obs_ready); end
    rst = 1'b0; drv_valid = 4'b1010; drv_bit = 4'b1000;
    tick();
    checks++;
    if (obs_mv !== 1'b0 || obs_ready !== 4'b0010) begin errors++; $display("FAIL resetmid_after got mv=%b ready=%b exp mv=0 ready=0010", obs_mv, obs_ready); end
    drv_valid = 4'b1000;
    tick();
    drv_valid = '0;
    tick();
    checks++;
    if (obs_mv !== 1'b0) begin errors++; $display("FAIL resetmid_ctx got mv=%b exp=0", obs_mv); end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int nmatch = 0;
    do_reset(2);
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < N; i++) begin
        drv_valid[i] = ($urandom_range(0, 3) != 0);
        drv_clr[i]   = ($urandom_range(0, 9) == 0);
      end
      tick();
      for (int i = 0; i < N; i++) if (obs_ready[i]) drv_bit[i] = 1'($urandom);
      if (obs_mv) nmatch++;
      checks++;
      if (obs_ready !== exp_ready || !$onehot0(obs_ready)) begin errors++; $display("FAIL random_ready cyc=%0d got=%b exp=%b", c, obs_ready, exp_ready); end
      checks++;
      if (obs_mv !== exp_mv || (exp_mv && obs_mch !== exp_mch)) begin errors++; $display("FAIL random_match cyc=%0d got mv=%b ch=%0d exp mv=%b ch=%0d", c, obs_mv, obs_mch, exp_mv, exp_mch); end
    end
    rst = 1'b0; drv_valid = '0; drv_clr = '0;
    $display("test_random matches=%0d", nmatch);
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_hist[i] = '0;
    clear_streams();
    test_reset();
    test_single_stream();
    test_interleave();
    test_back_to_back();
    test_contention();
    test_clear_mid();
    test_clear_collide();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_det_rr_scheduler.md
# seq_det_rr_scheduler

Time-shares one "101" sequence-detector next-state engine among N_CH serial bit-stream requesters. Each channel's 2-bit detector state is held in a per-channel context register. A round-robin arbiter grants one channel per cycle, and a match is reported as a one-cycle pulse tagged with the channel number. The block sits between the serial ingress lanes and the event-logging logic, replacing N separate single-stream detectors.

## Interface
- N_CH, default 4: number of requesting channels; legal range 2..16.
- CH_W, default $clog2(N_CH): width of the channel index.

- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  N_CH  per-channel bit offered.
- req_bit  in  N_CH  per-channel serial data bit; must be stable while its valid is high and its ready is low.
- req_ready  out  N_CH  one-hot-or-zero grant; a bit transfers when valid && ready.
- chan_clr  in  N_CH  per-channel synchronous context clear.
- match_valid  out  1  one-cycle pulse: a channel just reached the match state.
- match_ch  out  CH_W  channel that matched; meaningful only when match_valid is high.

## Operation
- Detector states per channel: S_IDLE=0, S_GOT1=1, S_GOT10=2, S_MATCH=3.
- Transitions as (in=0 / in=1):
  - S_IDLE: S_IDLE / S_GOT1.
  - S_GOT1: S_GOT10 / S_GOT1.
  - S_GOT10: S_IDLE / S_MATCH.
  - S_MATCH: S_GOT10 / S_GOT1.
- Overlapping matches count: for example, 10101 gives two matches.
- The shared next-state logic is applied only to the granted channel's context. Non-granted contexts hold their value.
- Eligible set = req_valid & ~chan_clr. A channel being cleared is never granted in that cycle.
- Round-robin arbitration:
  - Pointer rr_ptr (CH_W bits) gives the highest-priority channel.
  - Search upward from rr_ptr, wrapping at N_CH-1 to 0.
  - First eligible channel is granted; req_ready is asserted combinationally for that channel only.
  - After a grant to channel g, rr_ptr <= (g == N_CH-1) ? 0 : g+1.
  - With no grant, rr_ptr holds.
- chan_clr[i] forces context i to S_IDLE at the next edge, overriding any update. Several channels can be cleared at once.
- match_valid/match_ch are registered and set when the granted channel's next state is S_MATCH. A channel sitting in S_MATCH without further input does not re-pulse.

## Timing
- Reset values:
  - All contexts S_IDLE.
  - rr_ptr = 0.
  - match_valid = 0, match_ch = 0.
  - req_ready is combinational: 0 while all req_valid are low.
- Throughput: one accepted bit per cycle, aggregate across all channels.
- Per-channel throughput is 1/k, where k = number of continuously eligible channels.
- Latency: a bit accepted in cycle t updates its context at the end of t. If it completes "101", match_valid is high during cycle t+1 for exactly one cycle.
- Back-to-back matches on different channels give consecutive match_valid pulses with different match_ch values.
- reset asserted mid-stream:
  - Discards all partial patterns.
  - Suppresses any match pending for the next cycle: match_valid is 0 in the cycle after reset.
  - req_ready is 0 during reset cycles.
- Simultaneous chan_clr[i] and req_valid[i]: no transfer on channel i. Arbitration moves to the next eligible channel in the same cycle.

## Structure
- Shared package seq_det_pkg holds:
  - the state encoding constants S_IDLE..S_MATCH and the 2-bit state typedef;
  - the next-state function next_state(state, bit).
- Sub-module rr_arbiter (parameter N; inputs req[N], ptr; output gnt[N] one-hot-or-zero; output gnt_idx; output gnt_any) holds the wrap-around priority search.
- Top level holds the context array, rr_ptr, clear handling and the match register.

## Test plan
- Single stream: ch0 valid continuously with bits 1,0,1,0,1, others idle. Required: ch0 granted every cycle; match_valid=1 with match_ch=0 in the cycles after the 3rd and 5th accepted bits; no other pulses.
- Two-way interleave: ch0 bits 1,0,1 and ch1 bits 0,0,0, both valid from reset. Required: grants 0,1,0,1,0,1; exactly one match (ch0), in the cycle after grant 5.
- Full contention: all 4 channels valid for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3; req_ready never has more than one bit set; $onehot0 holds throughout.
- Clear mid-pattern: ch2 accepts 1,0; chan_clr[2] pulses; ch2 then accepts 1. Required: no match. A further 0,1 then gives one match with match_ch=2.
- Clear collides with valid: chan_clr[1] and req_valid[1:0] high with rr_ptr=1. Required: req_ready=0001; ch1 context becomes S_IDLE; rr_ptr becomes 1.
- Reset mid-operation: ch3 accepts 1,0,1 and reset is asserted in the same cycle as the final acceptance. Required: no match_valid pulse; all contexts S_IDLE; next grant goes to the lowest-numbered valid channel.
